// File: rtl/regfile_sequencer_if.sv
// Bundle between the register-file sequencer and its surroundings: instruction
// request in, register-file / bus / ALU controls out.
interface regfile_sequencer_if #(
    parameter int AW = 2
);
    // Handshake: Exec is a level request with no ready. The sequencer samples it
    // only while Tstep == T0 and captures INSTR on that rising edge. While an
    // instruction is in flight Exec and INSTR are ignored. Holding Exec high
    // starts the next instruction in the T0 cycle that follows Done.
    logic          Exec;
    logic [9:0]    INSTR;

    logic          ENW;
    logic [AW-1:0] WRA;
    logic          ENR0;
    logic [AW-1:0] RDA0;
    logic          ENR1;
    logic [AW-1:0] RDA1;
    logic          ExtEn;
    logic          Gout;
    logic          ALU_En;
    logic [2:0]    ALU_Fn;
    logic          BSel;
    logic [9:0]    Imm;
    logic          Done;
    logic [1:0]    Tstep;

    modport master (
        output Exec, INSTR,
        input  ENW, WRA, ENR0, RDA0, ENR1, RDA1, ExtEn, Gout,
        input  ALU_En, ALU_Fn, BSel, Imm, Done, Tstep
    );

    modport slave (
        input  Exec, INSTR,
        output ENW, WRA, ENR0, RDA0, ENR1, RDA1, ExtEn, Gout,
        output ALU_En, ALU_Fn, BSel, Imm, Done, Tstep
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Multi-cycle control sequencer: latches one instruction per Exec request and
// walks T0..T2, decoding register-file, shared-bus and ALU controls from (Tstep, IR).
module regfile_sequencer #(
    parameter int OPW = 4,
    parameter int AW  = 2
) (
    input  logic                CLKb,
    input  logic                RSTn,
    regfile_sequencer_if.slave  bus
);

    localparam int IW = 10;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    localparam logic [OPW-1:0] OP_LOAD = OPW'(0);
    localparam logic [OPW-1:0] OP_MOV  = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(6);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(7);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(8);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(9);

    tstep_e           r_state;
    tstep_e           w_next_state;
    logic [IW-1:0]    r_ir;

    logic [OPW-1:0]   w_op;
    logic [AW-1:0]    w_rx;
    logic [AW-1:0]    w_ry;
    logic [3:0]       w_imm4;
    logic             w_is_load;
    logic             w_is_mov;
    logic             w_is_alu2;
    logic             w_is_not;
    logic             w_is_imm;
    logic             w_is_multi;
    logic [2:0]       w_alu_fn;

    logic             w_enw;
    logic [AW-1:0]    w_wra;
    logic             w_enr0;
    logic [AW-1:0]    w_rda0;
    logic             w_enr1;
    logic [AW-1:0]    w_rda1;
    logic             w_exten;
    logic             w_gout;
    logic             w_alu_en;
    logic [2:0]       w_fn_out;
    logic             w_bsel;
    logic [IW-1:0]    w_imm;
    logic             w_done;

    assign w_op   = r_ir[IW-1 -: OPW];
    assign w_rx   = r_ir[4 +: AW];
    assign w_ry   = r_ir[2 +: AW];
    assign w_imm4 = r_ir[3:0];

    assign w_is_load  = (w_op == OP_LOAD);
    assign w_is_mov   = (w_op == OP_MOV);
    assign w_is_alu2  = (w_op >= OP_ADD) && (w_op <= OP_XOR);
    assign w_is_not   = (w_op == OP_NOT);
    assign w_is_imm   = (w_op == OP_ADDI) || (w_op == OP_SUBI);
    assign w_is_multi = w_is_alu2 || w_is_not || w_is_imm;

    // Register ops and NOT encode the function in opcode[2:0]; ADDI/SUBI map onto ADD/SUB.
    assign w_alu_fn = w_is_imm ? {2'b01, w_op[0]} : w_op[2:0];

    always_ff @(posedge CLKb or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= T0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == T0 && bus.Exec) begin
                r_ir <= bus.INSTR;
            end
        end
    end

    always_comb begin
        w_next_state = T0;
        case (r_state)
            T0:      w_next_state = bus.Exec ? T1 : T0;
            T1:      w_next_state = w_is_multi ? T2 : T0;
            T2:      w_next_state = T0;
            default: w_next_state = T0;
        endcase
    end

    always_comb begin
        w_enw    = 1'b0;
        w_wra    = '0;
        w_enr0   = 1'b0;
        w_rda0   = '0;
        w_enr1   = 1'b0;
        w_rda1   = '0;
        w_exten  = 1'b0;
        w_gout   = 1'b0;
        w_alu_en = 1'b0;
        w_fn_out = 3'b000;
        w_bsel   = 1'b0;
        w_imm    = {{(IW-4){1'b0}}, w_imm4};
        w_done   = 1'b0;
        case (r_state)
            T1: begin
                if (w_is_load) begin
                    w_exten = 1'b1;
                    w_enw   = 1'b1;
                    w_wra   = w_rx;
                    w_done  = 1'b1;
                end else if (w_is_mov) begin
                    w_enr0 = 1'b1;
                    w_rda0 = w_ry;
                    w_enw  = 1'b1;
                    w_wra  = w_rx;
                    w_done = 1'b1;
                end else if (w_is_multi) begin
                    w_enr0   = 1'b1;
                    w_rda0   = w_rx;
                    w_alu_en = 1'b1;
                    w_fn_out = w_alu_fn;
                    if (w_is_alu2) begin
                        w_enr1 = 1'b1;
                        w_rda1 = w_ry;
                    end
                    w_bsel = w_is_imm;
                end else begin
                    // Undefined opcodes retire as a NOP.
                    w_done = 1'b1;
                end
            end
            T2: begin
                w_gout   = 1'b1;
                w_enw    = 1'b1;
                w_wra    = w_rx;
                w_fn_out = w_alu_fn;
                w_done   = 1'b1;
            end
            T3: begin
                w_imm = '0;
            end
            default: begin
            end
        endcase
    end

    assign bus.ENW    = w_enw;
    assign bus.WRA    = w_wra;
    assign bus.ENR0   = w_enr0;
    assign bus.RDA0   = w_rda0;
    assign bus.ENR1   = w_enr1;
    assign bus.RDA1   = w_rda1;
    assign bus.ExtEn  = w_exten;
    assign bus.Gout   = w_gout;
    assign bus.ALU_En = w_alu_en;
    assign bus.ALU_Fn = w_fn_out;
    assign bus.BSel   = w_bsel;
    assign bus.Imm    = w_imm;
    assign bus.Done   = w_done;
    assign bus.Tstep  = r_state;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: per-scenario tasks compare the packed
// output vector against hand-computed control words.
module tb_regfile_sequencer;

  logic CLKb;
  logic RSTn;
  int   n_cmp;
  int   n_err;
  int   bus_conflicts;
  int   enw_bad;

  regfile_sequencer_if #(.AW(2)) bus ();

  regfile_sequencer #(.OPW(4), .AW(2)) dut (
    .CLKb (CLKb),
    .RSTn (RSTn),
    .bus  (bus)
  );

  // clock / reset
  initial CLKb = 1'b0;
  always #5 CLKb = ~CLKb;

  logic [28:0] obs;
  assign obs = {bus.ENW, bus.WRA, bus.ENR0, bus.RDA0, bus.ENR1, bus.RDA1,
                bus.ExtEn, bus.Gout, bus.ALU_En, bus.ALU_Fn, bus.BSel,
                bus.Imm, bus.Done, bus.Tstep};

  function automatic logic [28:0] ex(
    input logic enw, input logic [1:0] wra,
    input logic enr0, input logic [1:0] rda0,
    input logic enr1, input logic [1:0] rda1,
    input logic exten, input logic gout, input logic alu_en,
    input logic [2:0] fn, input logic bsel, input logic [3:0] imm4,
    input logic done, input logic [1:0] t);
    return {enw, wra, enr0, rda0, enr1, rda1, exten, gout, alu_en, fn, bsel,
            {6'b0, imm4}, done, t};
  endfunction

  // shared-bus and write-enable invariants, sampled mid-cycle
  always @(negedge CLKb) begin
    if ($countones({bus.ExtEn, bus.Gout, bus.ENR0}) > 1) bus_conflicts++;
    if (bus.ENW && (!bus.Done || bus.Tstep == 2'd0)) enw_bad++;
  end

  task automatic step();
    @(posedge CLKb);
    #2;
  endtask

  task automatic test_reset();
    logic [28:0] e;
    RSTn = 1'b0;
    bus.Exec = 1'b0;
    bus.INSTR = '0;
    #3;
    e = '0;
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL reset: got %h required %h", obs, e); end
    step();
    RSTn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL idle_%0d: got %h required %h", i, obs, e); end
    end
  endtask

  task automatic test_load();
    logic [28:0] e;
    bus.INSTR = 10'b0000_10_0000;
    bus.Exec = 1'b1;
    step();
    bus.Exec = 1'b0;
    e = ex(1, 2'd2, 0, 0, 0, 0, 1, 0, 0, 3'b000, 0, 4'd0, 1, 2'd1);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL load_t1: got %h required %h", obs, e); end
    step();
    e = '0;
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL load_back_t0: got %h required %h", obs, e); end
  endtask

  task automatic test_add();
    logic [28:0] e;
    bus.INSTR = 10'b0010_01_11_00;
    bus.Exec = 1'b1;
    step();
    bus.Exec = 1'b0;
    e = ex(0, 0, 1, 2'd1, 1, 2'd3, 0, 0, 1, 3'b010, 0, 4'd12, 0, 2'd1);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL add_t1: got %h required %h", obs, e); end
    step();
    e = ex(1, 2'd1, 0, 0, 0, 0, 0, 1, 0, 3'b010, 0, 4'd12, 1, 2'd2);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL add_t2: got %h required %h", obs, e); end
    step();
    e = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 4'd12, 0, 2'd0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL add_back_t0: got %h required %h", obs, e); end
  endtask

  task automatic test_immediate();
    logic [28:0] e;
    bus.INSTR = 10'b1000_11_0101;
    bus.Exec = 1'b1;
    step();
    bus.Exec = 1'b0;
    e = ex(0, 0, 1, 2'd3, 0, 0, 0, 0, 1, 3'b010, 1, 4'd5, 0, 2'd1);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL addi_t1: got %h required %h", obs, e); end
    step();
    e = ex(1, 2'd3, 0, 0, 0, 0, 0, 1, 0, 3'b010, 0, 4'd5, 1, 2'd2);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL addi_t2: got %h required %h", obs, e); end
    step();
    bus.INSTR = 10'b1001_00_1111;
    bus.Exec = 1'b1;
    step();
    bus.Exec = 1'b0;
    e = ex(0, 0, 1, 2'd0, 0, 0, 0, 0, 1, 3'b011, 1, 4'd15, 0, 2'd1);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL subi_t1: got %h required %h", obs, e); end
    step();
    e = ex(1, 2'd0, 0, 0, 0, 0, 0, 1, 0, 3'b011, 0, 4'd15, 1, 2'd2);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL subi_t2: got %h required %h", obs, e); end
    step();
  endtask

  task automatic test_alu_ops();
    logic [28:0] e;
    logic [3:0]  op;
    logic        two_src;
    for (int k = 2; k <= 7; k++) begin
      op = 4'(k);
      two_src = (k != 7);
      bus.INSTR = {op, 2'd2, 2'd1, 2'd0};
      bus.Exec = 1'b1;
      step();
      bus.Exec = 1'b0;
      e = ex(0, 0, 1, 2'd2, two_src, two_src ? 2'd1 : 2'd0, 0, 0, 1, op[2:0], 0, 4'd4, 0, 2'd1);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL alu_op%0d_t1: got %h required %h", k, obs, e); end
      step();
      e = ex(1, 2'd2, 0, 0, 0, 0, 0, 1, 0, op[2:0], 0, 4'd4, 1, 2'd2);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL alu_op%0d_t2: got %h required %h", k, obs, e); end
      step();
    end
  endtask

  task automatic test_reset_mid_op();
    logic [28:0] e;
    bus.INSTR = 10'b0011_10_01_00;
    bus.Exec = 1'b1;
    step();
    bus.Exec = 1'b0;
    e = ex(0, 0, 1, 2'd2, 1, 2'd1, 0, 0, 1, 3'b011, 0, 4'd4, 0, 2'd1);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL sub_t1: got %h required %h", obs, e); end
    #1;
    RSTn = 1'b0;
    #1;
    e = '0;
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL sub_async_rst: got %h required %h", obs, e); end
    step();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL sub_in_rst: got %h required %h", obs, e); end
    RSTn = 1'b1;
    step();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL sub_after_rst: got %h required %h", obs, e); end
  endtask

  task automatic test_back_to_back();
    logic [28:0] e;
    bus.INSTR = 10'b0001_01_10_00;
    bus.Exec = 1'b1;
    step();
    e = ex(1, 2'd1, 1, 2'd2, 0, 0, 0, 0, 0, 3'b000, 0, 4'd8, 1, 2'd1);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL mov_t1: got %h required %h", obs, e); end
    bus.INSTR = 10'b1100_00_0000;
    step();
    e = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 4'd8, 0, 2'd0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL b2b_t0: got %h required %h", obs, e); end
    step();
    bus.Exec = 1'b0;
    e = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 4'd0, 1, 2'd1);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL nop_t1: got %h required %h", obs, e); end
    step();
    e = '0;
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL nop_back_t0: got %h required %h", obs, e); end
  endtask

  task automatic test_exec_ignored();
    logic [28:0] e;
    bus.INSTR = 10'b0010_00_01_00;
    bus.Exec = 1'b1;
    step();
    e = ex(0, 0, 1, 2'd0, 1, 2'd1, 0, 0, 1, 3'b010, 0, 4'd4, 0, 2'd1);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL ign_t1: got %h required %h", obs, e); end
    bus.INSTR = 10'b0000_11_0000;
    step();
    e = ex(1, 2'd0, 0, 0, 0, 0, 0, 1, 0, 3'b010, 0, 4'd4, 1, 2'd2);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL ign_t2: got %h required %h", obs, e); end
    step();
    e = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 4'd4, 0, 2'd0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL ign_t0: got %h required %h", obs, e); end
    step();
    bus.Exec = 1'b0;
    e = ex(1, 2'd3, 0, 0, 0, 0, 1, 0, 0, 3'b000, 0, 4'd0, 1, 2'd1);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL ign_load_t1: got %h required %h", obs, e); end
    step();
  endtask

  task automatic test_invariants();
    n_cmp++;
    if (bus_conflicts !== 0) begin n_err++; $display("FAIL bus_conflict: got %0d required 0", bus_conflicts); end
    n_cmp++;
    if (enw_bad !== 0) begin n_err++; $display("FAIL enw_outside_done: got %0d required 0", enw_bad); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus_conflicts = 0;
    enw_bad = 0;
    test_reset();
    test_load();
    test_add();
    test_immediate();
    test_alu_ops();
    test_reset_mid_op();
    test_back_to_back();
    test_exec_ignored();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
